// File: rtl/sample_pdff.sv
// sample_pdff: STAGES-deep D flip-flop pipeline with asynchronous active-high reset
module sample_pdff #(
  parameter int WIDTH = 1,
  parameter int STAGES = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (WIDTH < 1 || STAGES < 1 || STAGES > 16) begin : g_bad_params
    $error("sample_pdff: WIDTH must be >= 1 and STAGES within 1..16");
  end
  logic [WIDTH-1:0] r_stage [STAGES];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= RESET_VALUE;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end
  assign q = r_stage[STAGES-1];
endmodule

// File: tb/tb_sample_pdff.sv
// tb_sample_pdff: directed checks of the default flop and an 8-bit 3-stage pipeline
module tb_sample_pdff;
  logic       clk = 1'b0;
  logic       r1, d1, q1;
  logic       r3;
  logic [7:0] d3, q3;
  int         n_checks = 0;
  int         n_fails = 0;

  always #5 clk = ~clk;

  sample_pdff u_dff (.clk(clk), .reset(r1), .d(d1), .q(q1));
  sample_pdff #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) u_pipe (
    .clk(clk), .reset(r3), .d(d3), .q(q3));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] pat;
    logic [7:0] pd [7];
    logic [7:0] pe [7];
    logic       rr, dd;
    logic [7:0] ms [4];
    pat = 5'b10110;
    pd = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    pe = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    ms = '{8'hA5, 8'hA5, 8'h20, 8'h21};
    r1 = 1'b1; d1 = 1'b1; r3 = 1'b1; d3 = 8'h00;
    #1;
    chk("rst_q1_t1", {7'd0, q1}, 8'h00);
    chk("rst_q3_t1", q3, 8'hA5);
    @(negedge clk);
    chk("rst_q1_hold1", {7'd0, q1}, 8'h00);
    @(negedge clk);
    chk("rst_q1_hold2", {7'd0, q1}, 8'h00);
    r1 = 1'b0;
    #1 chk("release_no_edge", {7'd0, q1}, 8'h00);
    @(negedge clk);
    chk("release_capture", {7'd0, q1}, 8'h01);
    for (int i = 4; i >= 0; i--) begin
      logic prev;
      prev = q1;
      d1 = pat[i];
      #1 chk("toggle_pre_edge", {7'd0, q1}, {7'd0, prev});
      @(negedge clk);
      chk("toggle", {7'd0, q1}, {7'd0, pat[i]});
    end
    d1 = 1'b1;
    @(negedge clk);
    chk("async_pre", {7'd0, q1}, 8'h01);
    #2 r1 = 1'b1;
    #1 chk("async_immediate", {7'd0, q1}, 8'h00);
    @(negedge clk);
    chk("async_held", {7'd0, q1}, 8'h00);
    r1 = 1'b0;
    #1 chk("async_release_wait", {7'd0, q1}, 8'h00);
    @(negedge clk);
    chk("async_follow", {7'd0, q1}, 8'h01);
    for (int run = 0; run < 2; run++) begin
      for (int k = 0; k < 10; k++) begin
        rr = 1'($urandom_range(0, 3) == 0);
        dd = 1'($urandom);
        r1 = rr; d1 = dd;
        #1 if (rr) chk("rand_async", {7'd0, q1}, 8'h00);
        @(negedge clk);
        chk("rand_model", {7'd0, q1}, {7'd0, rr ? 1'b0 : dd});
      end
    end
    chk("pipe_rst", q3, 8'hA5);
    r3 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      d3 = pd[k];
      @(negedge clk);
      chk("pipe_latency", q3, pe[k]);
    end
    d3 = 8'h10;
    @(negedge clk);
    d3 = 8'h11;
    @(negedge clk);
    d3 = 8'h12;
    #2 r3 = 1'b1;
    #1 chk("mid_async", q3, 8'hA5);
    @(negedge clk);
    chk("mid_held", q3, 8'hA5);
    r3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d3 = 8'h20 + 8'(k);
      @(negedge clk);
      chk("mid_flush", q3, ms[k]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
